// File: rtl/sha_bridge_pkg.sv
// sha_bridge_pkg: states, constants and hex encoding shared by the UART/SHA-256 bridge
package sha_bridge_pkg;
    typedef enum logic [2:0] {RECV, FEED, WAIT_HASH, SEND, SUFFIX, ERROR, DONE} state_t;
    localparam int HEX_LEN = 64;
    localparam logic [7:0] CR = 8'h0D;
    localparam logic [7:0] LF = 8'h0A;
    function automatic logic [7:0] hex_char(input logic [3:0] n, input logic upper);
        return n < 4'd10 ? 8'h30 + {4'd0, n} : (upper ? 8'h37 : 8'h57) + {4'd0, n};
    endfunction
endpackage

// File: rtl/sha256_uart_bridge_if.sv
// sha256_uart_bridge_if: uart_rx, sha256 core, uart_tx, display and status signals of the bridge
interface sha256_uart_bridge_if;
    logic rx_ready;
    logic [7:0] rx_data;
    logic sha_reset;
    logic [7:0] sha_data;
    logic sha_data_end;
    logic sha_delay;
    logic sha_hash_done;
    logic [255:0] sha_hash;
    logic tx_send;
    logic [7:0] tx_data;
    logic tx_busy;
    logic disp_valid;
    logic busy;
    logic overflow;
    logic [7:0] msg_count;
    modport master (
        input rx_ready, rx_data, sha_delay, sha_hash_done, sha_hash, tx_busy,
        output sha_reset, sha_data, sha_data_end, tx_send, tx_data, disp_valid, busy, overflow, msg_count
    );
    modport slave (
        output rx_ready, rx_data, sha_delay, sha_hash_done, sha_hash, tx_busy,
        input sha_reset, sha_data, sha_data_end, tx_send, tx_data, disp_valid, busy, overflow, msg_count
    );
endinterface

// File: rtl/tx_byte_sender.sv
// tx_byte_sender: issues one byte at a time to uart_tx, waiting for busy to rise and fall
module tx_byte_sender (
    input logic clk,
    input logic rst,
    input logic start,
    input logic [7:0] data,
    input logic tx_busy,
    output logic tx_send,
    output logic [7:0] tx_data,
    output logic fire
);
    logic guard, seen;
    logic [1:0] cnt;
    assign fire = start && !guard && !tx_busy;
    // if busy never rises within 2 cycles the transmitter is assumed to have taken the byte
    always_ff @(posedge clk)
        if (rst) begin
            tx_send <= 1'b0;
            tx_data <= 8'd0;
            guard <= 1'b0;
            seen <= 1'b0;
            cnt <= 2'd0;
        end else begin
            tx_send <= fire;
            if (fire) begin
                tx_data <= data;
                guard <= 1'b1;
                seen <= 1'b0;
                cnt <= 2'd0;
            end else if (guard) begin
                if (tx_busy) seen <= 1'b1;
                else if (seen || cnt == 2'd2) guard <= 1'b0;
                else cnt <= cnt + 2'd1;
            end
        end
endmodule

// File: rtl/sha256_uart_bridge.sv
// sha256_uart_bridge: buffers a UART message, hashes it, returns the digest as hex text
module sha256_uart_bridge
    import sha_bridge_pkg::*;
#(
    parameter int MAX_LEN = 64,
    parameter logic [7:0] TERM_CHAR = 8'h0A,
    parameter bit UPPER_HEX = 1'b0,
    parameter bit SEND_CRLF = 1'b1,
    parameter logic [7:0] ERR_CHAR = 8'h21
) (
    input logic clk,
    input logic master_reset,
    sha256_uart_bridge_if.master bus
);
    localparam int AW = $clog2(MAX_LEN);
    localparam logic [AW:0] FULL = (AW + 1)'(MAX_LEN);
    state_t state;
    logic [7:0] mem [MAX_LEN];
    logic [7:0] rdata, tx_byte, msg_count;
    logic [AW:0] len;
    logic [AW-1:0] rd, raddr;
    logic [255:0] sh;
    logic [5:0] idx;
    logic ovf_pending, err, overflow, disp_valid, start, fire, last, wr_en;
    assign last = {1'b0, rd} == len - 1'b1;
    assign wr_en = state == RECV && bus.rx_ready && bus.rx_data != TERM_CHAR && len < FULL;
    // read address runs one ahead of rd so the RAM output already holds the presented byte
    assign raddr = state == FEED ? (bus.sha_delay ? rd : rd + 1'b1) : '0;
    assign start = state inside {SEND, SUFFIX, ERROR};
    assign tx_byte = state == SEND ? hex_char(sh[255:252], UPPER_HEX) :
                     state == ERROR ? ERR_CHAR : (idx[0] ? LF : CR);
    assign bus.sha_reset = !(state inside {FEED, WAIT_HASH, SEND} || (state == SUFFIX && !err));
    assign bus.sha_data = state == FEED ? rdata : 8'd0;
    assign bus.sha_data_end = state == FEED && last;
    assign bus.busy = state != RECV;
    assign bus.overflow = overflow;
    assign bus.disp_valid = disp_valid;
    assign bus.msg_count = msg_count;
    tx_byte_sender u_tx (
        .clk(clk),
        .rst(master_reset),
        .start(start),
        .data(tx_byte),
        .tx_busy(bus.tx_busy),
        .tx_send(bus.tx_send),
        .tx_data(bus.tx_data),
        .fire(fire)
    );
    always_ff @(posedge clk) begin
        rdata <= mem[raddr];
        if (wr_en) mem[len[AW-1:0]] <= bus.rx_data;
    end
    always_ff @(posedge clk)
        if (master_reset) begin
            state <= RECV;
            len <= '0;
            rd <= '0;
            idx <= '0;
            sh <= '0;
            ovf_pending <= 1'b0;
            err <= 1'b0;
            overflow <= 1'b0;
            disp_valid <= 1'b0;
            msg_count <= 8'd0;
        end else begin
            disp_valid <= fire && state == SEND;
            case (state)
                RECV: if (bus.rx_ready) begin
                    if (bus.rx_data != TERM_CHAR) begin
                        if (len < FULL) len <= len + 1'b1;
                        else ovf_pending <= 1'b1;
                    end else if (ovf_pending) begin
                        state <= ERROR;
                        overflow <= 1'b1;
                        err <= 1'b1;
                        len <= '0;
                        ovf_pending <= 1'b0;
                        idx <= '0;
                    end else if (len != '0) begin
                        state <= FEED;
                        overflow <= 1'b0;
                        err <= 1'b0;
                        rd <= '0;
                        idx <= '0;
                    end
                end
                FEED: if (!bus.sha_delay) begin
                    rd <= rd + 1'b1;
                    if (last) state <= WAIT_HASH;
                end
                WAIT_HASH: if (bus.sha_hash_done) begin
                    sh <= bus.sha_hash;
                    state <= SEND;
                end
                SEND: if (fire) begin
                    sh <= sh << 4;
                    idx <= idx + 6'd1;
                    if (idx == 6'(HEX_LEN - 1)) state <= SEND_CRLF ? SUFFIX : DONE;
                end
                SUFFIX: if (fire) begin
                    idx <= idx + 6'd1;
                    if (idx[0]) state <= err ? RECV : DONE;
                end
                ERROR: if (fire) state <= SEND_CRLF ? SUFFIX : RECV;
                DONE: begin
                    msg_count <= msg_count + 8'd1;
                    len <= '0;
                    state <= RECV;
                end
                default: state <= RECV;
            endcase
        end
endmodule

// File: tb/tb_sha256_uart_bridge.sv
// tb_sha256_uart_bridge: directed message vectors against a stub sha256 core and uart_tx model
module tb_sha256_uart_bridge;
    typedef logic [7:0] q8_t [$];
    typedef struct packed {
        logic sr; logic [7:0] sd; logic se; logic ts; logic [7:0] td;
        logic dv; logic bz; logic ov; logic [7:0] mc;
    } snap_t;
    typedef struct {
        int inst; string msg; string resp; string fed; int disp; logic ovf; int cnt;
    } vec_t;
    localparam logic [255:0] ABC = 256'hba7816bf_8f01cfea_414140de_5dae2223_b00361a3_96177a9c_b410ff61_f20015ad;
    string H = "ba7816bf8f01cfea414140de5dae2223b00361a396177a9cb410ff61f20015ad";
    string HU = "BA7816BF8F01CFEA414140DE5DAE2223B00361A396177A9CB410FF61F20015AD";
    string CRLF = "\015\012";
    logic clk = 1'b0;
    logic [1:0] rst = 2'b11;
    logic rx_ready = 1'b0;
    logic [7:0] rx_data = 8'h00;
    logic stall_en = 1'b0;
    logic lose_busy = 1'b0;
    snap_t snap [2];
    q8_t txq [2], dispq [2], fedq [2], stallq [2], endq [2];
    int nsr [2];
    int n_chk = 0, n_fail = 0;
    vec_t rows [$];
    int k, mt, md, mf, mn, ms, me;
    always #5 clk = ~clk;
    // instance 0: MAX_LEN=4, lower-case hex, CR/LF; instance 1: MAX_LEN=64, upper-case hex, no suffix
    for (genvar g = 0; g < 2; g++) begin : gi
        sha256_uart_bridge_if bus ();
        sha256_uart_bridge #(.MAX_LEN(g == 0 ? 4 : 64), .UPPER_HEX(g == 1), .SEND_CRLF(g == 0)) dut (
            .clk(clk), .master_reset(rst[g]), .bus(bus)
        );
        logic [1:0] bcnt = 2'd0;
        logic [1:0] hcnt = 2'd0;
        logic fed_end = 1'b0;
        int nfed = 0, nst = 0;
        assign bus.rx_ready = rx_ready;
        assign bus.rx_data = rx_data;
        assign bus.tx_busy = bcnt != 2'd0;
        assign bus.sha_delay = stall_en && nfed == 1 && nst < 3;
        assign bus.sha_hash_done = hcnt == 2'd3;
        assign bus.sha_hash = ABC;
        assign snap[g] = {bus.sha_reset, bus.sha_data, bus.sha_data_end, bus.tx_send, bus.tx_data,
                          bus.disp_valid, bus.busy, bus.overflow, bus.msg_count};
        always @(posedge clk) begin
            if (bus.tx_send && !lose_busy) bcnt <= 2'd3;
            else if (bcnt != 2'd0) bcnt <= bcnt - 2'd1;
            if (bus.tx_send) txq[g].push_back(bus.tx_data);
            if (bus.disp_valid) dispq[g].push_back(bus.tx_data);
            if (!bus.sha_reset) nsr[g] <= nsr[g] + 1;
            if (bus.sha_reset) begin
                nfed <= 0;
                nst <= 0;
                hcnt <= 2'd0;
                fed_end <= 1'b0;
            end else if (fed_end) begin
                if (hcnt != 2'd3) hcnt <= hcnt + 2'd1;
            end else begin
                if (bus.sha_data_end) endq[g].push_back(bus.sha_data);
                if (bus.sha_delay) begin
                    nst <= nst + 1;
                    stallq[g].push_back(bus.sha_data);
                end else begin
                    fedq[g].push_back(bus.sha_data);
                    nfed <= nfed + 1;
                    fed_end <= bus.sha_data_end;
                end
            end
        end
    end
    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask
    task automatic chk_s(input string name, input string act, input string exp);
        n_chk++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got \"%s\" (%0d bytes), expected \"%s\" (%0d bytes)", name, act, act.len(), exp, exp.len());
        end
    endtask
    function automatic string qs(input q8_t q, input int from);
        string s = "";
        for (int i = from; i < q.size(); i++) s = $sformatf("%s%c", s, q[i]);
        return s;
    endfunction
    function automatic vec_t mk(input int inst, input string msg, input string resp, input string fed,
                                input int disp, input logic ovf, input int cnt);
        vec_t v;
        v.inst = inst; v.msg = msg; v.resp = resp; v.fed = fed; v.disp = disp; v.ovf = ovf; v.cnt = cnt;
        return v;
    endfunction
    task automatic send_byte(input logic [7:0] b);
        @(negedge clk);
        rx_ready = 1'b1;
        rx_data = b;
        @(negedge clk);
        rx_ready = 1'b0;
    endtask
    task automatic send_msg(input string m);
        for (int i = 0; i < m.len(); i++) send_byte(m[i]);
        send_byte(8'h0A);
    endtask
    task automatic wait_idle(input int n);
        int i = 0;
        repeat (2) @(negedge clk);
        while (snap[n].bz && i < 3000) begin
            @(negedge clk);
            i++;
        end
        chk($sformatf("idle_timeout[%0d]", n), snap[n].bz, 0);
        repeat (4) @(negedge clk);
    endtask
    initial begin
        #900000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end
    initial begin
        rows.push_back(mk(0, "abc", {H, CRLF}, "abc", 64, 1'b0, 1));
        rows.push_back(mk(0, "", "", "", 0, 1'b0, 1));
        rows.push_back(mk(0, "abcd", {H, CRLF}, "abcd", 64, 1'b0, 2));
        rows.push_back(mk(0, "abcdef", {"!", CRLF}, "", 0, 1'b1, 2));
        rows.push_back(mk(0, "abc", {H, CRLF}, "abc", 64, 1'b0, 3));
        rows.push_back(mk(1, "abc", HU, "abc", 64, 1'b0, 1));
        rows.push_back(mk(1, "a", HU, "a", 64, 1'b0, 2));
        repeat (3) @(negedge clk);
        for (int i = 0; i < 2; i++) chk($sformatf("reset_state[%0d]", i), snap[i], {1'b1, 29'd0});
        for (int r = 0; r < rows.size(); r++) begin
            k = rows[r].inst;
            rst = k == 0 ? 2'b10 : 2'b01;
            mt = txq[k].size(); md = dispq[k].size(); mf = fedq[k].size(); mn = nsr[k];
            send_msg(rows[r].msg);
            wait_idle(k);
            chk_s($sformatf("tx[%0d]", r), qs(txq[k], mt), rows[r].resp);
            chk_s($sformatf("fed[%0d]", r), qs(fedq[k], mf), rows[r].fed);
            chk($sformatf("disp_count[%0d]", r), dispq[k].size() - md, rows[r].disp);
            chk($sformatf("sha_reset_low[%0d]", r), nsr[k] != mn, rows[r].fed.len() != 0);
            chk($sformatf("overflow[%0d]", r), snap[k].ov, rows[r].ovf);
            chk($sformatf("msg_count[%0d]", r), snap[k].mc, rows[r].cnt);
        end
        stall_en = 1'b1;
        mt = txq[1].size(); mf = fedq[1].size(); ms = stallq[1].size(); me = endq[1].size();
        send_msg("abc");
        wait_idle(1);
        stall_en = 1'b0;
        chk_s("stall_hold", qs(stallq[1], ms), "bbb");
        chk_s("data_end", qs(endq[1], me), "c");
        chk_s("stall_fed", qs(fedq[1], mf), "abc");
        chk_s("stall_tx", qs(txq[1], mt), HU);
        lose_busy = 1'b1;
        mt = txq[1].size();
        send_msg("abc");
        wait_idle(1);
        lose_busy = 1'b0;
        chk_s("lost_busy_tx", qs(txq[1], mt), HU);
        chk("lost_busy_count", snap[1].mc, 4);
        mt = txq[1].size();
        send_msg("abc");
        for (int i = 0; i < 3000 && txq[1].size() - mt < 11; i++) @(negedge clk);
        chk("chars_before_reset", txq[1].size() - mt >= 11, 1);
        rst[1] = 1'b1;
        @(negedge clk);
        rst[1] = 1'b0;
        chk("abort_state", {snap[1].ts, snap[1].sr, snap[1].bz, snap[1].mc}, {1'b0, 1'b1, 1'b0, 8'd0});
        repeat (4) @(negedge clk);
        mt = txq[1].size(); mf = fedq[1].size();
        send_msg("abc");
        wait_idle(1);
        chk_s("after_abort_tx", qs(txq[1], mt), HU);
        chk_s("after_abort_fed", qs(fedq[1], mf), "abc");
        chk("after_abort_count", snap[1].mc, 1);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule

// File: doc/sha256_uart_bridge.md
Name: sha256_uart_bridge

Overview:
- Parametrised successor to the fixed 3-byte UART→SHA-256→UART path.
- Buffers a variable-length message from the UART receiver, up to MAX_LEN bytes and ended by a terminator byte, then feeds it byte-serially to the sha256 core.
- Streams the 256-bit digest as 64 hex characters, plus an optional CR/LF suffix, to uart_tx.
- Mirrors each character to the textRow display path.

Parameters:
- MAX_LEN, 64: message buffer depth in bytes (power of 2, 4..256).
- TERM_CHAR, 8'h0A: byte that ends a message; never hashed.
- UPPER_HEX, 0: 1 = hex digits A-F, 0 = a-f.
- SEND_CRLF, 1: 1 = append 8'h0D, 8'h0A after the digest (not mirrored to display).
- ERR_CHAR, 8'h21: byte sent in place of the digest on overflow.

Ports:
- clk  in  1  system clock
- master_reset  in  1  synchronous, active-high reset
- rx_ready  in  1  one-cycle strobe from uart_rx (byteReady)
- rx_data  in  8  received byte (dataIn), valid with rx_ready
- sha_reset  out  1  master_reset to sha256 core
- sha_data  out  8  data_in to sha256
- sha_data_end  out  1  high with the last message byte
- sha_delay  in  1  core not ready; hold current byte while high
- sha_hash_done  in  1  level, digest valid
- sha_hash  in  256  digest; bits [255:252] are the first hex char
- tx_send  out  1  one-cycle request to uart_tx
- tx_data  out  8  byte for uart_tx, stable from tx_send until busy drops
- tx_busy  in  1  uart_tx busy
- disp_valid  out  1  one-cycle strobe per digest char (textRow byteReady); data on tx_data
- busy  out  1  high in any state except RECV
- overflow  out  1  sticky until the next accepted message starts
- msg_count  out  8  completed digests, wraps 255→0

Behaviour:
- Reset values: sha_reset=1; sha_data=0, sha_data_end=0, tx_send=0, tx_data=0, disp_valid=0, busy=0, overflow=0, msg_count=0. State is RECV; length and write pointer are 0.
- An assertion of master_reset in any state aborts the operation in progress next cycle and discards the buffer.
- RECV: sha_reset=1.
  - On rx_ready with rx_data≠TERM_CHAR and len<MAX_LEN: write buf[len], len+=1.
  - If len==MAX_LEN: discard the byte and set ovf_pending.
  - On rx_ready with TERM_CHAR:
    - If ovf_pending: go to ERROR.
    - Else if len==0: ignore, stay in RECV, no output.
    - Else: go to FEED. Also clear overflow here when ovf_pending is 0.
- FEED:
  - sha_reset=0 from the first FEED cycle.
  - Present buf[rd]. Advance rd only on cycles with sha_delay=0.
  - sha_data_end=1 exactly while buf[len-1] is presented.
  - After the last byte is accepted: drop sha_data_end, go to WAIT_HASH.
  - One byte per cycle when sha_delay stays 0; a len-byte message takes len cycles.
- WAIT_HASH: wait for sha_hash_done=1, latch sha_hash into a 256-bit shift register, go to SEND. No timeout.
- SEND: for nibble index i=0..63 (MSB first):
  - Encode: 0-9 → 8'h30+n; 10-15 → 8'h61+n-10, or 8'h41+n-10 when UPPER_HEX.
  - Handshake per char: when tx_busy=0 and the guard is clear, drive tx_data, pulse tx_send and disp_valid for 1 cycle, set the guard.
  - The guard blocks the next send until tx_busy has been seen high and then low, or until 2 cycles with tx_busy never rising (lost-busy recovery).
  - After char 63 go to SUFFIX when SEND_CRLF, else DONE.
- SUFFIX: send 8'h0D then 8'h0A with the same handshake, disp_valid=0.
- ERROR: set overflow=1; send ERR_CHAR (disp_valid=0), then SUFFIX if enabled, then RECV. msg_count does not change.
- DONE (1 cycle): sha_reset=1, msg_count+=1, len=0, go to RECV.
- rx_ready while busy=1: byte dropped and not buffered; if it is TERM_CHAR it is also ignored. Concurrent messages are not queued.
- rx_ready coincident with master_reset: reset wins.

Decomposition:
- Shared package sha_bridge_pkg holds:
  - the state enum: RECV, FEED, WAIT_HASH, SEND, SUFFIX, ERROR, DONE;
  - HEX_LEN=64 and CR/LF constants;
  - a hex-encode function (nibble, upper) → byte.
- One natural sub-module: tx_byte_sender, which owns the tx_send/tx_busy guard handshake and is reused by SEND, SUFFIX and ERROR.
- Message buffer is an inferred MAX_LEN×8 RAM with a synchronous read; the FEED read pointer is prefetched one cycle ahead.

Test Plan:
- RX "abc",0x0A with a real sha256 core → TX "ba7816bf8f01cfea414140de5dae2223b00361a396177a9cb410ff61f20015ad",0x0D,0x0A; 64 disp_valid pulses; msg_count=1.
- UPPER_HEX=1, same input → first 8 chars "BA7816BF"; SEND_CRLF=0 → exactly 64 tx_send pulses and no suffix.
- Bare 0x0A in RECV → no tx_send, no sha_reset deassertion, msg_count unchanged.
- MAX_LEN=4, RX "abcdef",0x0A → TX 0x21,0x0D,0x0A; overflow=1; then RX "abc",0x0A → correct digest, overflow=0.
- sha_delay held high 3 cycles on byte 2 of "abc" → sha_data holds 0x62 across those cycles; sha_data_end high only with 0x63; digest unchanged.
- master_reset pulsed mid-SEND (after char 10) → next cycle tx_send=0, sha_reset=1, state RECV; rx "abc",0x0A afterwards yields the full correct digest.
